// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   KEY_* localparams : key index map (0-9 digits, A-D = 10-13, * = 14, # = 15)
//   press_state_t     : press FSM states
//   key_index()       : (row, col) matrix position -> key index
//   first_low()       : index of the lowest active-low bit in a key vector
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_AST  = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    localparam logic [15:0] KEYS_NONE = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        MULTI = 2'd2
    } press_state_t;

    // Physical layout: [1 2 3 A] [4 5 6 B] [7 8 9 C] [* 0 # D]
    function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] idx;
        case ({row, col})
            4'h0: idx = KEY_1;
            4'h1: idx = KEY_2;
            4'h2: idx = KEY_3;
            4'h3: idx = KEY_A;
            4'h4: idx = KEY_4;
            4'h5: idx = KEY_5;
            4'h6: idx = KEY_6;
            4'h7: idx = KEY_B;
            4'h8: idx = KEY_7;
            4'h9: idx = KEY_8;
            4'hA: idx = KEY_9;
            4'hB: idx = KEY_C;
            4'hC: idx = KEY_AST;
            4'hD: idx = KEY_0;
            4'hE: idx = KEY_HASH;
            default: idx = KEY_D;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] first_low(input logic [15:0] keys);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (!keys[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/kp_debounce.sv
// Full-matrix debouncer. Accepts a new key vector only after DEBOUNCE_FRAMES
// consecutive identical frames; any differing frame restarts the count.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   frame_done : one-cycle pulse, frame holds a complete scan
//   frame      : raw active-low key levels for the last scan
//   keys_n     : debounced active-low key levels
//   keys_upd   : one-cycle pulse in the cycle keys_n first shows a new value
module kp_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_done,
    input  logic [15:0] frame,
    output logic [15:0] keys_n,
    output logic        keys_upd
);

    localparam int CW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES - 1);

    logic [15:0]   prev_frame;
    logic [CW-1:0] stable_cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = '0;
        if (frame == prev_frame) begin
            cnt_next = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_frame <= KEYS_NONE;
            stable_cnt <= '0;
            keys_n     <= KEYS_NONE;
            keys_upd   <= 1'b0;
        end else begin
            keys_upd <= 1'b0;
            if (frame_done) begin
                prev_frame <= frame;
                stable_cnt <= cnt_next;
                if (cnt_next == CNT_MAX && frame != keys_n) begin
                    keys_n   <= frame;
                    keys_upd <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner: column drive, row synchronizer, frame capture,
// debounce and single-key press detection.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   row_n      : keypad rows, active-low, asynchronous to clk
//   col_n      : column drive, exactly one bit low
//   keys_n     : debounced active-low key levels, one bit per key index
//   key_strobe : one-cycle pulse on a clean single-key press
//   key_code   : index of the last accepted key, held until the next strobe
//
// Press FSM
//   state | meaning
//   IDLE  | no key down; a single-key press strobes
//   HELD  | one accepted key down; any further change leaves via MULTI or IDLE
//   MULTI | several keys seen; waits for full release, never strobes
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [15:0] keys_n,
    output logic        key_strobe,
    output logic [3:0]  key_code
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] dwell_cnt;
    logic [1:0]    col_idx;
    logic          dwell_end;
    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [15:0]   frame_buf;
    logic [15:0]   frame_next;
    logic          frame_done;
    logic          keys_upd;
    logic          one_low;
    logic          any_low;
    logic          strobe_set;

    press_state_t  state;
    press_state_t  state_next;

    assign dwell_end = (dwell_cnt == DW'(SCAN_DIV - 1));
    assign col_n     = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    // Rows of the active column overwrite their four slots in the frame buffer.
    always_comb begin
        frame_next = frame_buf;
        for (int r = 0; r < 4; r++) begin
            frame_next[key_index(2'(r), col_idx)] = row_sync[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt  <= '0;
            col_idx    <= 2'd0;
            frame_buf  <= KEYS_NONE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= dwell_end && (col_idx == 2'd3);
            if (dwell_end) begin
                dwell_cnt <= '0;
                col_idx   <= col_idx + 2'd1;
                frame_buf <= frame_next;
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
        end
    end

    kp_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .frame_done(frame_done),
        .frame     (frame_buf),
        .keys_n    (keys_n),
        .keys_upd  (keys_upd)
    );

    assign one_low = ($countones(~keys_n) == 1);
    assign any_low = (keys_n != KEYS_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (keys_upd) begin
            case (state)
                IDLE: begin
                    if (one_low)      state_next = HELD;
                    else if (any_low) state_next = MULTI;
                end
                HELD:    state_next = any_low ? MULTI : IDLE;
                MULTI:   if (!any_low) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        strobe_set = keys_upd && (state == IDLE) && one_low;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_strobe <= 1'b0;
            key_code   <= 4'd0;
        end else begin
            key_strobe <= strobe_set;
            if (strobe_set) key_code <= first_low(keys_n);
        end
    end

endmodule
